// File: rtl/register_file.sv
// Architectural register file with per-register rename tags for an out-of-order core.
// Optional macro REG_COMMIT_BYPASS_EN forwards a same-cycle ROB commit onto the read ports.
module register_file #(
  parameter int REG_NUM  = 32,
  parameter int DATA_W   = 32,
  parameter int ROB_ID_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic [4:0]          rs1_from_dsp,
  input  logic [4:0]          rs2_from_dsp,
  output logic [DATA_W-1:0]   V1_to_dsp,
  output logic [DATA_W-1:0]   V2_to_dsp,
  output logic [ROB_ID_W-1:0] Q1_to_dsp,
  output logic [ROB_ID_W-1:0] Q2_to_dsp,
  input  logic                ena_from_dsp,
  input  logic [4:0]          rd_from_dsp,
  input  logic [ROB_ID_W-1:0] rob_id_from_dsp,
  input  logic                commit_flag,
  input  logic [4:0]          rd_from_rob,
  input  logic [ROB_ID_W-1:0] Q_from_rob,
  input  logic [DATA_W-1:0]   V_from_rob,
  input  logic                flush_from_rob
);

  logic [DATA_W-1:0]   value_q [REG_NUM];
  logic [DATA_W-1:0]   value_d [REG_NUM];
  logic [ROB_ID_W-1:0] tag_q   [REG_NUM];
  logic [ROB_ID_W-1:0] tag_d   [REG_NUM];

  // The commit clear is evaluated first so that a same-cycle rename to the
  // same register overwrites it; a flush discards all renames but keeps the
  // commit value write (jal/jalr link register).
  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;
    if (rdy) begin
      if (commit_flag && rd_from_rob != 5'd0) begin
        value_d[rd_from_rob] = V_from_rob;
        if (tag_q[rd_from_rob] == Q_from_rob) begin
          tag_d[rd_from_rob] = '0;
        end
      end
      if (flush_from_rob) begin
        for (int i = 0; i < REG_NUM; i++) begin
          tag_d[i] = '0;
        end
      end else if (ena_from_dsp && rd_from_dsp != 5'd0) begin
        tag_d[rd_from_dsp] = rob_id_from_dsp;
      end
    end
    value_d[0] = '0;
    tag_d[0]   = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else begin
      value_q <= value_d;
      tag_q   <= tag_d;
    end
  end

  always_comb begin
    V1_to_dsp = '0;
    Q1_to_dsp = '0;
    if (rs1_from_dsp != 5'd0) begin
      V1_to_dsp = value_q[rs1_from_dsp];
      Q1_to_dsp = tag_q[rs1_from_dsp];
`ifdef REG_COMMIT_BYPASS_EN
      if (rdy && commit_flag && rd_from_rob == rs1_from_dsp &&
          tag_q[rs1_from_dsp] == Q_from_rob) begin
        V1_to_dsp = V_from_rob;
        Q1_to_dsp = '0;
      end
`endif
    end
  end

  always_comb begin
    V2_to_dsp = '0;
    Q2_to_dsp = '0;
    if (rs2_from_dsp != 5'd0) begin
      V2_to_dsp = value_q[rs2_from_dsp];
      Q2_to_dsp = tag_q[rs2_from_dsp];
`ifdef REG_COMMIT_BYPASS_EN
      if (rdy && commit_flag && rd_from_rob == rs2_from_dsp &&
          tag_q[rs2_from_dsp] == Q_from_rob) begin
        V2_to_dsp = V_from_rob;
        Q2_to_dsp = '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: expected reads are queued when stimulus
// is driven and compared on both read ports when drained.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic [4:0]  rs1_from_dsp, rs2_from_dsp;
  logic [31:0] V1_to_dsp, V2_to_dsp;
  logic [4:0]  Q1_to_dsp, Q2_to_dsp;
  logic        ena_from_dsp;
  logic [4:0]  rd_from_dsp, rob_id_from_dsp;
  logic        commit_flag;
  logic [4:0]  rd_from_rob, Q_from_rob;
  logic [31:0] V_from_rob;
  logic        flush_from_rob;

  int errCount = 0;
  int checkCount = 0;

  typedef struct {
    string       tag;
    logic [4:0]  rs;
    logic [31:0] v;
    logic [4:0]  q;
  } readExp_t;

  readExp_t sbQueue[$];

  register_file dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .rs1_from_dsp(rs1_from_dsp), .rs2_from_dsp(rs2_from_dsp),
    .V1_to_dsp(V1_to_dsp), .V2_to_dsp(V2_to_dsp),
    .Q1_to_dsp(Q1_to_dsp), .Q2_to_dsp(Q2_to_dsp),
    .ena_from_dsp(ena_from_dsp), .rd_from_dsp(rd_from_dsp),
    .rob_id_from_dsp(rob_id_from_dsp),
    .commit_flag(commit_flag), .rd_from_rob(rd_from_rob),
    .Q_from_rob(Q_from_rob), .V_from_rob(V_from_rob),
    .flush_from_rob(flush_from_rob)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expectRead(input string tag, input logic [4:0] rs, input logic [31:0] v, input logic [4:0] q);
    readExp_t e;
    e.tag = tag; e.rs = rs; e.v = v; e.q = q;
    sbQueue.push_back(e);
  endtask

  // Each queued expectation is checked through both read ports.
  task automatic drainScoreboard();
    readExp_t e;
    while (sbQueue.size() > 0) begin
      e = sbQueue.pop_front();
      rs1_from_dsp = e.rs;
      rs2_from_dsp = e.rs;
      #1;
      checkOutput({e.tag, ".V1"}, V1_to_dsp, e.v);
      checkOutput({e.tag, ".Q1"}, {27'd0, Q1_to_dsp}, {27'd0, e.q});
      checkOutput({e.tag, ".V2"}, V2_to_dsp, e.v);
      checkOutput({e.tag, ".Q2"}, {27'd0, Q2_to_dsp}, {27'd0, e.q});
    end
  endtask

  task automatic driveInputs(input logic cf, input logic [4:0] crd, input logic [4:0] cq,
                             input logic [31:0] cv, input logic en, input logic [4:0] rrd,
                             input logic [4:0] rid, input logic fl);
    commit_flag = cf; rd_from_rob = crd; Q_from_rob = cq; V_from_rob = cv;
    ena_from_dsp = en; rd_from_dsp = rrd; rob_id_from_dsp = rid;
    flush_from_rob = fl;
  endtask

  task automatic applyStimulus(input logic cf, input logic [4:0] crd, input logic [4:0] cq,
                               input logic [31:0] cv, input logic en, input logic [4:0] rrd,
                               input logic [4:0] rid, input logic fl);
    driveInputs(cf, crd, cq, cv, en, rrd, rid, fl);
    @(posedge clk); #1;
    driveInputs(1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b0;
    rs1_from_dsp = 5'd0; rs2_from_dsp = 5'd0;
    driveInputs(1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;

    expectRead("rst_x5", 5'd5, 32'd0, 5'd0);
    expectRead("rst_x0", 5'd0, 32'd0, 5'd0);
    expectRead("rst_x31", 5'd31, 32'd0, 5'd0);
    drainScoreboard();

    rdy = 1'b1;
    applyStimulus(1'b0, 5'd0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd3, 1'b0);
    expectRead("ren_x5", 5'd5, 32'd0, 5'd3);
    drainScoreboard();
    applyStimulus(1'b1, 5'd5, 5'd3, 32'h1234, 1'b0, 5'd0, 5'd0, 1'b0);
    expectRead("commit_x5", 5'd5, 32'h1234, 5'd0);
    drainScoreboard();

    // Younger rename must survive the older commit.
    applyStimulus(1'b0, 5'd0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd3, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd7, 1'b0);
    applyStimulus(1'b1, 5'd5, 5'd3, 32'hAA, 1'b0, 5'd0, 5'd0, 1'b0);
    expectRead("younger_x5", 5'd5, 32'hAA, 5'd7);
    drainScoreboard();

    applyStimulus(1'b0, 5'd0, 5'd0, 32'd0, 1'b1, 5'd6, 5'd2, 1'b0);
    applyStimulus(1'b1, 5'd6, 5'd2, 32'h66, 1'b1, 5'd6, 5'd4, 1'b0);
    expectRead("samecyc_x6", 5'd6, 32'h66, 5'd4);
    drainScoreboard();

    applyStimulus(1'b0, 5'd0, 5'd0, 32'd0, 1'b1, 5'd1, 5'd1, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 32'd0, 1'b1, 5'd2, 5'd2, 1'b0);
    applyStimulus(1'b1, 5'd1, 5'd1, 32'h80, 1'b1, 5'd3, 5'd5, 1'b1);
    expectRead("flush_x1", 5'd1, 32'h80, 5'd0);
    expectRead("flush_x2", 5'd2, 32'd0, 5'd0);
    expectRead("flush_x3", 5'd3, 32'd0, 5'd0);
    expectRead("flush_x5", 5'd5, 32'hAA, 5'd0);
    expectRead("flush_x6", 5'd6, 32'h66, 5'd0);
    drainScoreboard();

    applyStimulus(1'b1, 5'd0, 5'd0, 32'hFFFF, 1'b1, 5'd0, 5'd3, 1'b0);
    expectRead("x0_hard", 5'd0, 32'd0, 5'd0);
    drainScoreboard();

    applyStimulus(1'b1, 5'd8, 5'd0, 32'h88, 1'b1, 5'd9, 5'd6, 1'b0);
    expectRead("indep_x8", 5'd8, 32'h88, 5'd0);
    expectRead("indep_x9", 5'd9, 32'd0, 5'd6);
    drainScoreboard();

    rdy = 1'b0;
    applyStimulus(1'b1, 5'd8, 5'd0, 32'hDEAD, 1'b1, 5'd10, 5'd1, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    expectRead("frozen_x8", 5'd8, 32'h88, 5'd0);
    expectRead("frozen_x9", 5'd9, 32'd0, 5'd6);
    expectRead("frozen_x10", 5'd10, 32'd0, 5'd0);
    drainScoreboard();

    rdy = 1'b1;
    applyStimulus(1'b0, 5'd0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd9, 1'b0);
    driveInputs(1'b1, 5'd7, 5'd9, 32'h55, 1'b0, 5'd0, 5'd0, 1'b0);
`ifdef REG_COMMIT_BYPASS_EN
    expectRead("bypass_x7", 5'd7, 32'h55, 5'd0);
`else
    expectRead("nobypass_x7", 5'd7, 32'd0, 5'd9);
`endif
    drainScoreboard();
    @(posedge clk); #1;
    driveInputs(1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    expectRead("after_x7", 5'd7, 32'h55, 5'd0);
    drainScoreboard();

    // Reset wins over simultaneous commit/rename, even with rdy low.
    rst = 1'b1; rdy = 1'b0;
    applyStimulus(1'b1, 5'd8, 5'd0, 32'h1, 1'b1, 5'd9, 5'd2, 1'b0);
    rst = 1'b0;
    expectRead("rst2_x8", 5'd8, 32'd0, 5'd0);
    expectRead("rst2_x9", 5'd9, 32'd0, 5'd0);
    expectRead("rst2_x1", 5'd1, 32'd0, 5'd0);
    drainScoreboard();

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
